uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter between the two player controllers. Each controller presents its 8-bit encoded packet continuously; this block detects changes, coalesces updates, arbitrates round-robin, tags each frame with its source ID in bit 6, and sequences the `uart_tx` serializer through a start/busy handshake. It also emits a periodic keepalive resend of both packets.

---
 rtl/uart_tx_scheduler.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmitter between the two player controllers. Packet
// changes are detected against the last byte sent per source, updates that
// arrive during a frame are coalesced, contending sources are served
// round-robin, and bit 6 of every frame carries the source ID. A free-running
// keepalive counter forces a periodic resend of both packets.
module uart_tx_scheduler #(
  parameter int KEEPALIVE_CYCLES = 1000000,
  parameter int GAP_CYCLES       = 16,
  parameter int ACK_TIMEOUT      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  p1_data,
  input  logic [7:0]  p2_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        tx_src,
  output logic [15:0] frame_count,
  output logic        err_ack
);

  localparam int KA_W  = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [KA_W-1:0]  KA_LAST  = KA_W'(KEEPALIVE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_GAP       = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0][7:0]  last_sent_q, last_sent_d;
  logic [1:0]       ka_pend_q, ka_pend_d;
  logic             rr_last_q, rr_last_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_src_q, tx_src_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             err_ack_q, err_ack_d;
  logic [KA_W-1:0]  ka_cnt_q, ka_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;

  logic [1:0] pend;
  logic       grant_src;
  logic [7:0] grant_byte;
  logic       ka_wrap;

  // A source needs service when its live packet differs from what was last
  // sent, or when a keepalive/retry is owed to it.
  assign pend[0] = (p1_data != last_sent_q[0]) | ka_pend_q[0];
  assign pend[1] = (p2_data != last_sent_q[1]) | ka_pend_q[1];

  // With both pending, the source not served last wins; otherwise the lone one.
  assign grant_src  = (&pend) ? ~rr_last_q : pend[1];
  assign grant_byte = grant_src ? p2_data : p1_data;
  assign ka_wrap    = (ka_cnt_q == KA_LAST);

  // Next-state logic for the sequencer, arbitration and keepalive counter.
  always_comb begin
    // NOTE: every _d gets a hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    last_sent_d   = last_sent_q;
    ka_pend_d     = ka_pend_q;
    rr_last_d     = rr_last_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    tx_src_d      = tx_src_q;
    frame_count_d = frame_count_q;
    err_ack_d     = err_ack_q;
    gap_cnt_d     = gap_cnt_q;
    ack_cnt_d     = ack_cnt_q;
    ka_cnt_d      = ka_wrap ? '0 : ka_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (|pend) begin
          tx_data_d              = {grant_byte[7], grant_src, grant_byte[5:0]};
          last_sent_d[grant_src] = grant_byte;
          ka_pend_d[grant_src]   = 1'b0;
          rr_last_d              = grant_src;
          tx_src_d               = grant_src;
          tx_start_d             = 1'b1;
          ack_cnt_d              = '0;
          state_d                = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          // Serializer never answered: flag it and owe this source a resend.
          err_ack_d           = 1'b1;
          ka_pend_d[tx_src_q] = 1'b1;
          state_d             = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          frame_count_d = frame_count_q + 16'd1;
          gap_cnt_d     = '0;
          state_d       = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      default: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
    endcase

    // Applied last so a keepalive set overrides a same-cycle grant clear.
    if (ka_wrap) begin
      ka_pend_d = 2'b11;
    end
  end

  // State registers; async reset returns every output to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_sent_q   <= '0;
      ka_pend_q     <= 2'b11;
      rr_last_q     <= 1'b1;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_src_q      <= 1'b0;
      frame_count_q <= 16'd0;
      err_ack_q     <= 1'b0;
      ka_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      ack_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      last_sent_q   <= last_sent_d;
      ka_pend_q     <= ka_pend_d;
      rr_last_q     <= rr_last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      tx_src_q      <= tx_src_d;
      frame_count_q <= frame_count_d;
      err_ack_q     <= err_ack_d;
      ka_cnt_q      <= ka_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      ack_cnt_q     <= ack_cnt_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign tx_src      = tx_src_q;
  assign frame_count = frame_count_q;
  assign err_ack     = err_ack_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler with a small uart_tx model and a
// queue of expected frames.
module tb_uart_tx_scheduler;

  localparam int KA         = 100;
  localparam int GAP        = 2;
  localparam int ACK        = 4;
  // Model busy rises one cycle after tx_start and falls BUSY_AFTER cycles
  // after tx_start.
  localparam int BUSY_AFTER = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  p1_data, p2_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_src;
  logic [15:0] frame_count;
  logic        err_ack;

  uart_tx_scheduler #(
    .KEEPALIVE_CYCLES(KA),
    .GAP_CYCLES      (GAP),
    .ACK_TIMEOUT     (ACK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p1_data    (p1_data),
    .p2_data    (p2_data),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_src     (tx_src),
    .frame_count(frame_count),
    .err_ack    (err_ack)
  );

  always #5 clk = ~clk;

  // uart_tx model; mute makes it ignore tx_start entirely.
  bit model_mute = 1'b0;
  int busy_rem;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      busy_rem <= 0;
    end else if (tx_busy) begin
      if (busy_rem == 0) tx_busy <= 1'b0;
      else               busy_rem <= busy_rem - 1;
    end else if (tx_start && !model_mute) begin
      tx_busy  <= 1'b1;
      busy_rem <= BUSY_AFTER - 2;
    end
  end

  typedef struct {
    logic       src;
    logic [7:0] data;        // raw source byte before tagging
    bit         from_inputs; // byte is whatever the source held at the grant
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_starts;
  int   last_start_cyc;
  bit   prev_start;
  int   n_checks;
  int   n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic src, input logic [7:0] data, input bit from_inputs = 1'b0);
    exp_t e;
    e.src = src;
    e.data = data;
    e.from_inputs = from_inputs;
    sb_q.push_back(e);
  endtask

  // One clock; outputs sampled 1 time unit after the edge, before new stimulus.
  task automatic tick();
    exp_t       e;
    logic [7:0] d;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_start) check("start_pulse_width", tx_start, 1'b0);
    prev_start = (tx_start === 1'b1);
    if (tx_start === 1'b1) begin
      n_starts++;
      last_start_cyc = cyc;
      check("frame_expected", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        d = e.from_inputs ? (e.src ? p2_data : p1_data) : e.data;
        check("frame_src", tx_src, e.src);
        check("frame_data", tx_data, {d[7], e.src, d[5:0]});
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (n_starts < target && i < budget) begin
      tick();
      i++;
    end
    check(tag, n_starts >= target, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    prev_start = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    int s0;
    int ts;
    rst = 1'b1;
    p1_data = 8'h05;
    p2_data = 8'h05;
    n_checks = 0;
    n_pass = 0;
    n_starts = 0;

    // Post-reset send order, spacing, then keepalive resends.
    do_reset();
    check("reset_tx_start", tx_start, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_tx_src", tx_src, 1'b0);
    check("reset_frame_count", frame_count, 16'd0);
    check("reset_err_ack", err_ack, 1'b0);
    s0 = n_starts;
    push(1'b0, 8'h05);
    push(1'b1, 8'h05);
    wait_starts(s0 + 1, 5, "a_first_start");
    check("a_first_cyc", last_start_cyc, 1);
    ts = last_start_cyc;
    wait_starts(s0 + 2, 30, "a_second_start");
    check("a_start_to_start", last_start_cyc - ts, 14);
    push(1'b0, 8'h05);
    push(1'b1, 8'h05);
    wait_starts(s0 + 3, 120, "ka1_p1_start");
    check("ka1_p1_cyc", last_start_cyc, 101);
    wait_starts(s0 + 4, 30, "ka1_p2_start");
    check("ka1_p2_cyc", last_start_cyc, 115);
    push(1'b0, 8'h05);
    push(1'b1, 8'h05);
    wait_starts(s0 + 5, 120, "ka2_p1_start");
    check("ka2_p1_cyc", last_start_cyc, 201);
    wait_starts(s0 + 6, 30, "ka2_p2_start");
    check("ka2_p2_cyc", last_start_cyc, 215);
    run_cycles(20);
    check("a_frame_count", frame_count, 16'd6);
    check("a_sb_drained", sb_q.size(), 0);

    // Coalescing: two P1 updates during a P1 frame yield one 0x07 frame.
    p1_data = 8'h05;
    p2_data = 8'h05;
    do_reset();
    s0 = n_starts;
    push(1'b0, 8'h05);
    push(1'b1, 8'h05);
    wait_starts(s0 + 1, 5, "b_first_start");
    tick();
    p1_data = 8'h06;
    tick();
    p1_data = 8'h07;
    push(1'b0, 8'h07);
    wait_starts(s0 + 3, 60, "b_three_starts");
    check("b_coalesced_cyc", last_start_cyc, 29);
    run_cycles(50);
    check("b_sb_drained", sb_q.size(), 0);
    check("b_frame_count", frame_count, 16'd3);

    // Round-robin: both sources change every cycle for 20 frames.
    do_reset();
    s0 = n_starts;
    for (int i = 0; i < 20; i++) push(1'(i % 2), 8'h00, 1'b1);
    for (int i = 0; i < 400 && n_starts < s0 + 20; i++) begin
      p1_data = 8'(cyc);
      p2_data = 8'(cyc) ^ 8'hC3;
      tick();
    end
    check("c_twenty_starts", n_starts - s0, 20);
    run_cycles(12);
    check("c_frame_count", frame_count, 16'd20);
    check("c_sb_drained", sb_q.size(), 0);

    // Ack timeout: serializer stops answering, P1 is retried.
    p1_data = 8'h05;
    p2_data = 8'h05;
    do_reset();
    s0 = n_starts;
    push(1'b0, 8'h05);
    push(1'b1, 8'h05);
    wait_starts(s0 + 2, 30, "d_initial_starts");
    run_cycles(15);
    check("d_frame_count_before", frame_count, 16'd2);
    check("d_err_ack_before", err_ack, 1'b0);
    model_mute = 1'b1;
    p1_data = 8'hFA;
    push(1'b0, 8'hFA);
    push(1'b0, 8'hFA);
    wait_starts(s0 + 3, 5, "d_start");
    check("d_change_latency", last_start_cyc, 31);
    ts = last_start_cyc;
    for (int i = 1; i < ACK; i++) begin
      tick();
      check("d_err_ack_early", err_ack, 1'b0);
    end
    tick();
    check("d_err_ack_rise", err_ack, 1'b1);
    tick();
    check("d_retry_cyc", last_start_cyc, ts + ACK + 1);
    check("d_frame_count_hold", frame_count, 16'd2);
    model_mute = 1'b0;

    // Async reset mid-WAIT_DONE of the retried frame.
    run_cycles(5);
    check("e_busy_before_reset", tx_busy, 1'b1);
    check("e_sb_drained", sb_q.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    check("e_async_tx_start", tx_start, 1'b0);
    check("e_async_frame_count", frame_count, 16'd0);
    check("e_async_err_ack", err_ack, 1'b0);
    check("e_async_tx_data", tx_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    prev_start = 1'b0;
    s0 = n_starts;
    push(1'b0, 8'hFA);
    push(1'b1, 8'h05);
    wait_starts(s0 + 1, 5, "e_first_after_reset");
    check("e_first_cyc", last_start_cyc, 1);
    wait_starts(s0 + 2, 30, "e_second_after_reset");
    check("e_sb_drained_end", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
